// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_seq_pkg
//  Description : Shared types for the multi-channel ADC sequencer. Holds the
//                FSM state encoding and the channel-scan helper.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_seq_pkg;

    // The FSM state codes are exported on state_out, so they are fixed values
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_HOLD      = 3'd2,
        ST_SOC       = 3'd3,
        ST_CONV      = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    // Result of a channel search: valid flag plus channel index
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ch_pick_t;

    // Lowest set bit of mask whose index is >= from. The mask is padded to
    // 16 bits by the caller, which covers the largest supported channel count.
    function automatic ch_pick_t next_set_bit(input logic [15:0] mask,
                                              input logic [4:0]  from);
        ch_pick_t r;
        r = '0;
        // Scanning downwards leaves the lowest qualifying index in r
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage : adc_seq_pkg
`default_nettype wire

// File: rtl/adc_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : adc_rate_gen
//  Description : Sample-rate generator. A prescaler produces a tick every
//                PRESCALE clocks; a period counter counts ticks and fires a
//                one-clock sample trigger every max(samp_div_in,1) ticks.
//                Both counters are held at zero while run is low.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_rate_gen
    import adc_seq_pkg::*;
#(
    parameter int PRESCALE = 10,
    parameter int DIV_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run,
    input  logic [DIV_W-1:0] samp_div_in,
    output logic             samp_trig_out
);

    localparam int PRS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRS_W-1:0] prs_q, prs_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic             w_tick;
    logic             w_wrap;
    logic [DIV_W-1:0] w_div_eff;

    // A programmed period of zero behaves like a period of one tick
    assign w_div_eff = (samp_div_in == '0) ? DIV_W'(1) : samp_div_in;
    assign w_tick    = (prs_q == PRS_W'(PRESCALE - 1));
    // >= so a period shortened mid-count still wraps instead of rolling over
    assign w_wrap    = (per_q >= (w_div_eff - DIV_W'(1)));

    assign samp_trig_out = run & w_tick & w_wrap;

    // Next-state for prescaler and period counter
    always_comb begin
        prs_d = prs_q;
        per_d = per_q;
        if (!run) begin
            prs_d = '0;
            per_d = '0;
        end else begin
            prs_d = w_tick ? '0 : prs_q + PRS_W'(1);
            if (w_tick) begin
                per_d = w_wrap ? '0 : per_q + DIV_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prs_q <= '0;
            per_q <= '0;
        end else begin
            prs_q <= prs_d;
            per_q <= per_d;
        end
    end

endmodule : adc_rate_gen
`default_nettype wire

// File: rtl/adc_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adc_multi_seq
//  Description : N-channel ADC conversion sequencer. On each sample trigger it
//                latches the channel mask and converts every enabled channel
//                in ascending order (SOC pulse, wait for EOC), stalling while
//                the sample FIFO is full. Signals end of sequence and flags
//                triggers that arrive while a sequence is still running.
//                Optional EOC timeout: define ADC_SEQ_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_multi_seq
    import adc_seq_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CH_W     = $clog2(N_CH),
    parameter int PRESCALE = 10,
    parameter int DIV_W    = 16,
    parameter int TMO_CYC  = 1024
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             start_in,
    input  logic             free_run_in,
    input  logic [N_CH-1:0]  ch_mask_in,
    input  logic [DIV_W-1:0] samp_div_in,
    input  logic             eoc_in,
    input  logic             full_in,
    output logic             soc_out,
    output logic [CH_W-1:0]  ch_sel_out,
    output logic             samp_trig_out,
    output logic             int_out,
    output logic             ovr_out,
    output logic [2:0]       state_out
);

    seq_state_t      state_q, state_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0] ch_sel_q, ch_sel_d;
    logic            soc_q, soc_d;
    logic            int_q, int_d;
    logic            ovr_q, ovr_d;
    logic            start_q;

    logic            w_trig;
    logic            w_run;
    logic            w_start_rise;
    logic            w_busy;
    logic            w_tmo_abort;
    ch_pick_t        w_first;
    ch_pick_t        w_next;
    logic            w_unused_idx;

    assign w_run        = (state_q != ST_IDLE);
    assign w_start_rise = start_in & ~start_q;
    assign w_busy       = (state_q == ST_HOLD) || (state_q == ST_SOC) ||
                          (state_q == ST_CONV) || (state_q == ST_DONE);

    // First channel of a new mask, and the channel following the current one
    assign w_first      = next_set_bit(16'(ch_mask_in), 5'd0);
    assign w_next       = next_set_bit(16'(mask_q), 5'(ch_sel_q) + 5'd1);
    assign w_unused_idx = ^{w_first.idx, w_next.idx};

    adc_rate_gen #(
        .PRESCALE (PRESCALE),
        .DIV_W    (DIV_W)
    ) u_rate_gen (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .run           (w_run),
        .samp_div_in   (samp_div_in),
        .samp_trig_out (w_trig)
    );

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Cycle counter restarts on every entry into CONV
    always_comb begin
        tmo_d = (state_q == ST_CONV) ? tmo_q + TMO_W'(1) : '0;
    end

    // An EOC on the last allowed cycle still counts as in time
    assign w_tmo_abort = (state_q == ST_CONV) && en_in && !eoc_in &&
                         (tmo_q == TMO_W'(TMO_CYC - 1));

    // Timeout counter register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic w_unused_tmo;
    assign w_tmo_abort  = 1'b0;
    assign w_unused_tmo = (TMO_CYC > 0);
`endif

    // Sequencer next state, mask latch, channel pointer and output pulses
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_sel_d = ch_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (en_in && start_in && (ch_mask_in != '0)) begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (w_trig) begin
                    // A mask cleared before the trigger leaves nothing to scan
                    if (w_first.found) begin
                        mask_d   = ch_mask_in;
                        ch_sel_d = w_first.idx[CH_W-1:0];
                        state_d  = ST_HOLD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!full_in) begin
                    state_d = ST_SOC;
                end
            end
            ST_SOC: begin
                state_d = ST_CONV;
            end
            ST_CONV: begin
                if (w_tmo_abort) begin
                    state_d = ST_IDLE;
                end else if (eoc_in) begin
                    if (w_next.found) begin
                        ch_sel_d = w_next.idx[CH_W-1:0];
                        state_d  = ST_HOLD;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = (free_run_in && start_in) ? ST_WAIT_TRIG : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable aborts from any state and beats a coincident EOC
        if (!en_in) begin
            state_d  = ST_IDLE;
            mask_d   = mask_q;
            ch_sel_d = ch_sel_q;
        end

        soc_d = (state_d == ST_SOC);
        int_d = (state_d == ST_DONE) || w_tmo_abort;
    end

    // Sticky overrun: set by a dropped trigger or an EOC timeout
    always_comb begin
        ovr_d = ovr_q;
        if (!en_in || w_start_rise) begin
            ovr_d = 1'b0;
        end else if ((w_trig && w_busy) || w_tmo_abort) begin
            ovr_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            ch_sel_q <= '0;
            soc_q    <= 1'b0;
            int_q    <= 1'b0;
            ovr_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_sel_q <= ch_sel_d;
            soc_q    <= soc_d;
            int_q    <= int_d;
            ovr_q    <= ovr_d;
            start_q  <= start_in;
        end
    end

    assign soc_out       = soc_q;
    assign ch_sel_out    = ch_sel_q;
    assign samp_trig_out = w_trig;
    assign int_out       = int_q;
    assign ovr_out       = ovr_q;
    assign state_out     = state_q;

endmodule : adc_multi_seq
`default_nettype wire

// File: tb/tb_adc_multi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_multi_seq
//  Description : Directed self-checking bench for adc_multi_seq (4 channels,
//                PRESCALE 10, period 3 ticks, EOC 5 clocks after SOC).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_multi_seq;

    localparam int N_CH     = 4;
    localparam int CH_W     = 2;
    localparam int PRESCALE = 10;
    localparam int DIV_W    = 16;
    localparam int TMO_CYC  = 64;

    logic             clk_in      = 1'b0;
    logic             rst_in      = 1'b0;
    logic             en_in       = 1'b0;
    logic             start_in    = 1'b0;
    logic             free_run_in = 1'b0;
    logic [N_CH-1:0]  ch_mask_in  = '0;
    logic [DIV_W-1:0] samp_div_in = 16'd3;
    logic             eoc_in      = 1'b0;
    logic             full_in     = 1'b0;
    logic             soc_out;
    logic [CH_W-1:0]  ch_sel_out;
    logic             samp_trig_out;
    logic             int_out;
    logic             ovr_out;
    logic [2:0]       state_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int soc_cyc[$];
    int soc_ch[$];
    int trig_cyc[$];
    int int_cyc[$];

    bit eoc_auto = 1'b1;
    int eoc_cnt  = 0;

    adc_multi_seq #(
        .N_CH     (N_CH),
        .PRESCALE (PRESCALE),
        .DIV_W    (DIV_W),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .en_in         (en_in),
        .start_in      (start_in),
        .free_run_in   (free_run_in),
        .ch_mask_in    (ch_mask_in),
        .samp_div_in   (samp_div_in),
        .eoc_in        (eoc_in),
        .full_in       (full_in),
        .soc_out       (soc_out),
        .ch_sel_out    (ch_sel_out),
        .samp_trig_out (samp_trig_out),
        .int_out       (int_out),
        .ovr_out       (ovr_out),
        .state_out     (state_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Event log, sampled mid-cycle
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (soc_out) begin
                soc_cyc.push_back(cyc);
                soc_ch.push_back(int'(ch_sel_out));
            end
            if (samp_trig_out) trig_cyc.push_back(cyc);
            if (int_out)       int_cyc.push_back(cyc);
        end
    end

    // ADC model: EOC pulse 5 clocks after each SOC
    always @(negedge clk_in) begin
        if (soc_out && eoc_auto) begin
            eoc_cnt = 5;
            eoc_in  = 1'b0;
        end else if (eoc_cnt == 1) begin
            eoc_cnt = 0;
            eoc_in  = 1'b1;
        end else begin
            if (eoc_cnt > 0) eoc_cnt--;
            eoc_in = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic clear_log();
        soc_cyc.delete();
        soc_ch.delete();
        trig_cyc.delete();
        int_cyc.delete();
    endtask

    // Advance to 1 time unit after the posedge that starts cycle 'target'
    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        en_in      = 1'b1;
        start_in   = 1'b1;
        ch_mask_in = 4'b1111;
        repeat (4) @(posedge clk_in);
        #1;
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        checks++; if ({soc_out, samp_trig_out, int_out, ovr_out} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {soc_out, samp_trig_out, int_out, ovr_out}); end
        checks++; if (ch_sel_out !== 2'd0) begin errors++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel_out); end
        start_in   = 1'b0;
        ch_mask_in = 4'b1011;
        rst_in     = 1'b1;
        wait_cyc(cyc + 2);
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got %0d expected 0", state_out); end
    endtask

    task automatic test_single_seq();
        int t0;
        clear_log();
        eoc_auto   = 1'b1;
        free_run_in = 1'b0;
        ch_mask_in = 4'b1011;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 1);
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL single_wait_trig: got %0d expected 1", state_out); end
        wait_cyc(t0 + 2);
        start_in = 1'b0;
        wait_cyc(t0 + 29);
        checks++; if (samp_trig_out !== 1'b0) begin errors++; $display("FAIL single_trig_early: got %b expected 0", samp_trig_out); end
        wait_cyc(t0 + 30);
        checks++; if (samp_trig_out !== 1'b1) begin errors++; $display("FAIL single_trig_time: got %b expected 1", samp_trig_out); end
        wait_cyc(t0 + 32);
        checks++; if ({state_out, soc_out, ch_sel_out} !== {3'd3, 1'b1, 2'd0}) begin errors++; $display("FAIL single_first_soc: got st=%0d soc=%b ch=%0d expected st=3 soc=1 ch=0", state_out, soc_out, ch_sel_out); end
        wait_cyc(t0 + 80);
        checks++;
        if (soc_ch.size() != 3) begin
            errors++; $display("FAIL single_soc_count: got %0d expected 3", soc_ch.size());
        end else if ({soc_ch[0], soc_ch[1], soc_ch[2]} !== {32'd0, 32'd1, 32'd3}) begin
            errors++; $display("FAIL single_soc_channels: got %0d,%0d,%0d expected 0,1,3", soc_ch[0], soc_ch[1], soc_ch[2]);
        end else if ({soc_cyc[0] - t0, soc_cyc[1] - t0, soc_cyc[2] - t0} !== {32'd32, 32'd39, 32'd46}) begin
            errors++; $display("FAIL single_soc_timing: got +%0d,+%0d,+%0d expected +32,+39,+46", soc_cyc[0] - t0, soc_cyc[1] - t0, soc_cyc[2] - t0);
        end
        checks++;
        if (int_cyc.size() != 1) begin
            errors++; $display("FAIL single_int_count: got %0d expected 1", int_cyc.size());
        end else if (int_cyc[0] - t0 != 52) begin
            errors++; $display("FAIL single_int_time: got +%0d expected +52", int_cyc[0] - t0);
        end
        checks++; if (trig_cyc.size() != 1) begin errors++; $display("FAIL single_trig_count: got %0d expected 1", trig_cyc.size()); end
        checks++; if ({state_out, ch_sel_out, ovr_out} !== {3'd0, 2'd3, 1'b0}) begin errors++; $display("FAIL single_end_state: got st=%0d ch=%0d ovr=%b expected st=0 ch=3 ovr=0", state_out, ch_sel_out, ovr_out); end
    endtask

    task automatic test_free_run();
        int t0;
        clear_log();
        free_run_in = 1'b1;
        ch_mask_in  = 4'b1011;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 52);
        checks++; if ({state_out, int_out} !== {3'd5, 1'b1}) begin errors++; $display("FAIL free_done: got st=%0d int=%b expected st=5 int=1", state_out, int_out); end
        wait_cyc(t0 + 55);
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL free_between: got %0d expected 1", state_out); end
        wait_cyc(t0 + 91);
        checks++;
        if (trig_cyc.size() != 3) begin
            errors++; $display("FAIL free_trig_count: got %0d expected 3", trig_cyc.size());
        end else if ({trig_cyc[0] - t0, trig_cyc[1] - t0, trig_cyc[2] - t0} !== {32'd30, 32'd60, 32'd90}) begin
            errors++; $display("FAIL free_trig_period: got +%0d,+%0d,+%0d expected +30,+60,+90", trig_cyc[0] - t0, trig_cyc[1] - t0, trig_cyc[2] - t0);
        end
        checks++;
        if (soc_ch.size() != 6) begin
            errors++; $display("FAIL free_soc_count: got %0d expected 6", soc_ch.size());
        end else if ({soc_ch[3], soc_ch[4], soc_ch[5], soc_cyc[3] - t0} !== {32'd0, 32'd1, 32'd3, 32'd62}) begin
            errors++; $display("FAIL free_second_seq: got ch %0d,%0d,%0d at +%0d expected 0,1,3 at +62", soc_ch[3], soc_ch[4], soc_ch[5], soc_cyc[3] - t0);
        end
        checks++; if (int_cyc.size() != 2) begin errors++; $display("FAIL free_int_count: got %0d expected 2", int_cyc.size()); end
        en_in       = 1'b0;
        start_in    = 1'b0;
        free_run_in = 1'b0;
        wait_cyc(t0 + 92);
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL free_disable: got %0d expected 0", state_out); end
        en_in = 1'b1;
        wait_cyc(t0 + 120);
        checks++; if ({int_cyc.size(), soc_ch.size()} !== {32'd2, 32'd6}) begin errors++; $display("FAIL free_after_disable: got int=%0d soc=%0d expected int=2 soc=6", int_cyc.size(), soc_ch.size()); end
    endtask

    task automatic test_full_hold();
        int t0;
        clear_log();
        ch_mask_in = 4'b1011;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 2);
        start_in = 1'b0;
        wait_cyc(t0 + 37);
        full_in = 1'b1;
        wait_cyc(t0 + 38);
        checks++; if (state_out !== 3'd2) begin errors++; $display("FAIL full_hold_enter: got %0d expected 2", state_out); end
        wait_cyc(t0 + 61);
        checks++; if ({state_out, ovr_out} !== {3'd2, 1'b1}) begin errors++; $display("FAIL full_overrun: got st=%0d ovr=%b expected st=2 ovr=1", state_out, ovr_out); end
        wait_cyc(t0 + 77);
        checks++; if ({state_out, soc_ch.size()} !== {3'd2, 32'd1}) begin errors++; $display("FAIL full_stall: got st=%0d socs=%0d expected st=2 socs=1", state_out, soc_ch.size()); end
        full_in = 1'b0;
        wait_cyc(t0 + 78);
        checks++; if ({state_out, soc_out, ch_sel_out} !== {3'd3, 1'b1, 2'd1}) begin errors++; $display("FAIL full_resume: got st=%0d soc=%b ch=%0d expected st=3 soc=1 ch=1", state_out, soc_out, ch_sel_out); end
        wait_cyc(t0 + 100);
        checks++;
        if (int_cyc.size() != 1) begin
            errors++; $display("FAIL full_int_count: got %0d expected 1", int_cyc.size());
        end else if (int_cyc[0] - t0 != 91) begin
            errors++; $display("FAIL full_int_time: got +%0d expected +91", int_cyc[0] - t0);
        end
        checks++; if ({state_out, ovr_out, soc_ch.size()} !== {3'd0, 1'b1, 32'd3}) begin errors++; $display("FAIL full_end: got st=%0d ovr=%b socs=%0d expected st=0 ovr=1 socs=3", state_out, ovr_out, soc_ch.size()); end
    endtask

    task automatic test_eoc_withheld();
        int t0;
        clear_log();
        eoc_auto = 1'b0;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 1);
        checks++; if (ovr_out !== 1'b0) begin errors++; $display("FAIL withheld_start_clears: got %b expected 0", ovr_out); end
        wait_cyc(t0 + 2);
        start_in = 1'b0;
        wait_cyc(t0 + 60);
        checks++; if ({state_out, ovr_out} !== {3'd4, 1'b0}) begin errors++; $display("FAIL withheld_before_trig: got st=%0d ovr=%b expected st=4 ovr=0", state_out, ovr_out); end
        wait_cyc(t0 + 61);
        checks++; if (ovr_out !== 1'b1) begin errors++; $display("FAIL withheld_overrun: got %b expected 1", ovr_out); end
        wait_cyc(t0 + 65);
        start_in = 1'b1;
        wait_cyc(t0 + 66);
        checks++; if ({state_out, ovr_out} !== {3'd4, 1'b0}) begin errors++; $display("FAIL withheld_rise_clears: got st=%0d ovr=%b expected st=4 ovr=0", state_out, ovr_out); end
        start_in = 1'b0;
        wait_cyc(t0 + 70);
        en_in = 1'b0;
        wait_cyc(t0 + 71);
        checks++; if ({state_out, int_cyc.size()} !== {3'd0, 32'd0}) begin errors++; $display("FAIL withheld_abort: got st=%0d ints=%0d expected st=0 ints=0", state_out, int_cyc.size()); end
        en_in    = 1'b1;
        eoc_auto = 1'b1;
        wait_cyc(t0 + 75);
    endtask

    task automatic test_abort_on_eoc();
        int t0;
        clear_log();
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 2);
        start_in = 1'b0;
        wait_cyc(t0 + 37);
        checks++; if (state_out !== 3'd4) begin errors++; $display("FAIL abort_in_conv: got %0d expected 4", state_out); end
        en_in = 1'b0;
        wait_cyc(t0 + 38);
        checks++; if ({state_out, ch_sel_out} !== {3'd0, 2'd0}) begin errors++; $display("FAIL abort_idle: got st=%0d ch=%0d expected st=0 ch=0", state_out, ch_sel_out); end
        wait_cyc(t0 + 39);
        en_in = 1'b1;
        wait_cyc(t0 + 80);
        checks++; if ({soc_ch.size(), int_cyc.size(), trig_cyc.size()} !== {32'd1, 32'd0, 32'd1}) begin errors++; $display("FAIL abort_quiet: got socs=%0d ints=%0d trigs=%0d expected 1,0,1", soc_ch.size(), int_cyc.size(), trig_cyc.size()); end
    endtask

    task automatic test_zero_mask();
        int t0;
        clear_log();
        ch_mask_in = 4'b0000;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 45);
        checks++; if ({state_out, trig_cyc.size(), soc_ch.size()} !== {3'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL zero_mask: got st=%0d trigs=%0d socs=%0d expected 0,0,0", state_out, trig_cyc.size(), soc_ch.size()); end
        start_in   = 1'b0;
        ch_mask_in = 4'b1011;
        wait_cyc(t0 + 47);
    endtask

`ifdef ADC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        clear_log();
        eoc_auto = 1'b0;
        t0 = cyc;
        start_in = 1'b1;
        wait_cyc(t0 + 2);
        start_in = 1'b0;
        wait_cyc(t0 + 96);
        checks++; if ({state_out, int_out} !== {3'd4, 1'b0}) begin errors++; $display("FAIL timeout_waiting: got st=%0d int=%b expected st=4 int=0", state_out, int_out); end
        wait_cyc(t0 + 97);
        checks++; if ({state_out, int_out, ovr_out} !== {3'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL timeout_abort: got st=%0d int=%b ovr=%b expected st=0 int=1 ovr=1", state_out, int_out, ovr_out); end
        wait_cyc(t0 + 110);
        checks++; if (int_cyc.size() != 1) begin errors++; $display("FAIL timeout_int_once: got %0d expected 1", int_cyc.size()); end
        eoc_auto = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_seq();
        test_free_run();
        test_full_hold();
        test_eoc_withheld();
        test_abort_on_eoc();
        test_zero_mask();
`ifdef ADC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adc_multi_seq
`default_nettype wire
